// File: rtl/book_delta_serializer_pkg.sv
// Shared types for the order-book delta serializer: book entry, output word, FSM state.
`default_nettype none

package book_delta_serializer_pkg;

  localparam int ENTRY_W = 88;

  typedef struct packed {
    logic [63:0] price;
    logic [15:0] quantity;
    logic [7:0]  num_orders;
  } book_entry_t;

  typedef struct packed {
    logic [31:0] sec_id;
    logic        side;
    logic [3:0]  level;
    logic [2:0]  rsvd;
    book_entry_t entry;
  } out_word_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  function automatic out_word_t make_word(input logic [31:0] sec_id, input logic side,
                                          input logic [3:0] level, input book_entry_t e);
    out_word_t w;
    w.sec_id = sec_id;
    w.side   = side;
    w.level  = level;
    w.rsvd   = 3'b000;
    w.entry  = e;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/book_delta_serializer_prio_enc.sv
// delta_prio_enc: lowest-set-bit encoder returning index, any-set and exactly-one-set flags.
`default_nettype none

module delta_prio_enc #(
  parameter int N     = 20,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] index,
  output logic             found,
  output logic             onehot_remaining
);

  logic [N-1:0] lsb_cleared;

  // Scan downward so the last hit written is the lowest set bit.
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) index = IDX_W'(i);
    end
  end

  assign lsb_cleared      = mask & (mask - {{(N-1){1'b0}}, 1'b1});
  assign found            = |mask;
  assign onehot_remaining = found && (lsb_cleared == '0);

endmodule

`default_nettype wire

// File: rtl/book_delta_serializer.sv
// Emits changed order-book levels as 128-bit words; BOOK_DELTA_FULL_REFRESH_EN adds refresh_req.
`default_nettype none

module book_delta_serializer
  import book_delta_serializer_pkg::*;
#(
  parameter int SEC_ID = 123,
  parameter int LEVELS = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    orderbook_ready,
  input  logic [88*LEVELS-1:0]    bids_in,
  input  logic [88*LEVELS-1:0]    asks_in,
`ifdef BOOK_DELTA_FULL_REFRESH_EN
  input  logic                    refresh_req,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic [15:0]             coalesce_cnt
);

  localparam int N     = 2 * LEVELS;
  localparam int IDX_W = $clog2(N);

  state_t            state, state_nxt;
  book_entry_t       prev     [N];
  book_entry_t       cur      [N];
  book_entry_t       in_e     [N];
  book_entry_t       prev_nxt [N];
  book_entry_t       cur_nxt  [N];
  logic [N-1:0]      mask, mask_nxt, cap_mask, mask_hs, idx_oh;
  logic [IDX_W-1:0]  idx, enc_idx, lvl_full;
  logic              enc_found, enc_one, enc_side;
  logic              pending;
  logic              hs, last_hs, capture, refresh;
  out_word_t         word_nxt;

  genvar gk;
  generate
    for (gk = 0; gk < N; gk++) begin : g_split
      if (gk < LEVELS) begin : g_bid
        assign in_e[gk] = bids_in[88*gk +: 88];
      end else begin : g_ask
        assign in_e[gk] = asks_in[88*(gk-LEVELS) +: 88];
      end
    end
  endgenerate

`ifdef BOOK_DELTA_FULL_REFRESH_EN
  logic refresh_lat;
  assign refresh = refresh_req | refresh_lat;
`else
  assign refresh = 1'b0;
`endif

  assign hs      = out_valid && out_ready;
  assign idx_oh  = {{(N-1){1'b0}}, 1'b1} << idx;
  assign mask_hs = mask & ~idx_oh;
  assign last_hs = hs && (mask_hs == '0);
  // A pending snapshot is consumed from IDLE, one cycle after the final handshake.
  assign capture = ((state == ST_IDLE) && (orderbook_ready || pending)) ||
                   (last_hs && orderbook_ready);
  assign busy    = (state == ST_EMIT);

  // Compare against prev as it will be after this edge's handshake commits.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      prev_nxt[k] = (hs && (idx == IDX_W'(k))) ? cur[k] : prev[k];
      cur_nxt[k]  = capture ? in_e[k] : cur[k];
      cap_mask[k] = refresh || (in_e[k] != prev_nxt[k]);
    end
  end

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    if (capture) begin
      mask_nxt  = cap_mask;
      state_nxt = (|cap_mask) ? ST_EMIT : ST_IDLE;
    end else if (hs) begin
      mask_nxt = mask_hs;
      if (last_hs) state_nxt = ST_IDLE;
    end
  end

  delta_prio_enc #(.N(N), .IDX_W(IDX_W)) u_enc (
    .mask             (mask_nxt),
    .index            (enc_idx),
    .found            (enc_found),
    .onehot_remaining (enc_one)
  );

  assign enc_side = (enc_idx >= IDX_W'(LEVELS));
  assign lvl_full = enc_side ? (enc_idx - IDX_W'(LEVELS)) : enc_idx;

  always_comb begin
    word_nxt = '0;
    if (enc_found && (state_nxt == ST_EMIT)) begin
      word_nxt = make_word(32'(SEC_ID), enc_side, 4'(lvl_full), cur_nxt[enc_idx]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      mask         <= '0;
      idx          <= '0;
      pending      <= 1'b0;
      coalesce_cnt <= 16'h0000;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      for (int k = 0; k < N; k++) begin
        prev[k] <= '0;
        cur[k]  <= '0;
      end
    end else begin
      state     <= state_nxt;
      mask      <= mask_nxt;
      idx       <= enc_idx;
      out_valid <= (state_nxt == ST_EMIT);
      out_last  <= (state_nxt == ST_EMIT) && enc_one;
      out_data  <= word_nxt;
      for (int k = 0; k < N; k++) begin
        prev[k] <= prev_nxt[k];
        cur[k]  <= cur_nxt[k];
      end
      if (capture) begin
        pending <= 1'b0;
      end else if ((state == ST_EMIT) && orderbook_ready) begin
        pending <= 1'b1;
        if (pending && (coalesce_cnt != 16'hFFFF)) coalesce_cnt <= coalesce_cnt + 16'h0001;
      end
    end
  end

`ifdef BOOK_DELTA_FULL_REFRESH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_lat <= 1'b0;
    end else if (capture) begin
      refresh_lat <= 1'b0;
    end else if (refresh_req) begin
      refresh_lat <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_book_delta_serializer.sv
// Directed self-checking bench for book_delta_serializer (SEC_ID=123, LEVELS=10).
`default_nettype none

module tb_book_delta_serializer;

  localparam int L = 10;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              orderbook_ready = 1'b0;
  logic [88*L-1:0]   bids_in = '0;
  logic [88*L-1:0]   asks_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [127:0]      out_data;
  logic              out_last;
  logic              busy;
  logic [15:0]       coalesce_cnt;
`ifdef BOOK_DELTA_FULL_REFRESH_EN
  logic              refresh_req = 1'b0;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [87:0]  mb [L];
  logic [87:0]  ma [L];
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  book_delta_serializer #(.SEC_ID(123), .LEVELS(L)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .orderbook_ready (orderbook_ready),
    .bids_in         (bids_in),
    .asks_in         (asks_in),
`ifdef BOOK_DELTA_FULL_REFRESH_EN
    .refresh_req     (refresh_req),
`endif
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .busy            (busy),
    .coalesce_cnt    (coalesce_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [87:0] mk(input logic [63:0] p, input logic [15:0] q, input logic [7:0] n);
    return {p, q, n};
  endfunction

  function automatic logic [127:0] wd(input logic side, input int lvl, input logic [87:0] e);
    return {32'd123, side, 4'(lvl), 3'b000, e};
  endfunction

  task automatic set_bid(input int i, input logic [87:0] e);
    mb[i] = e;
    bids_in[88*i +: 88] = e;
  endtask

  task automatic set_ask(input int i, input logic [87:0] e);
    ma[i] = e;
    asks_in[88*i +: 88] = e;
  endtask

  task automatic pulse();
    orderbook_ready = 1'b1;
    @(negedge clk);
    orderbook_ready = 1'b0;
  endtask

  // Called at the negedge where the first word is already visible; out_ready must be 1.
  task automatic expect_stream(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_valid%0d", tag, i), out_valid, 1'b1);
      check($sformatf("%s_data%0d", tag, i), out_data, exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), out_last, (i == n - 1));
      @(negedge clk);
    end
    check($sformatf("%s_done", tag), out_valid, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    logic any;
    for (int i = 0; i < L; i++) begin
      mb[i] = '0;
      ma[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", out_data, 128'd0);
    check("rst_cnt", coalesce_cnt, 16'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single changed entry, valid the cycle after capture
    set_bid(0, mk(64'hAE, 16'd1, 8'd1));
    out_ready = 1'b1;
    pulse();
    check("t1_busy", busy, 1'b1);
    exp_q.push_back(wd(1'b0, 0, mb[0]));
    expect_stream("t1");
    check("t1_idle", busy, 1'b0);

    // Unchanged book -> no output
    pulse();
    any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      any = any | out_valid | busy;
      @(negedge clk);
    end
    check("t2_silent", any, 1'b0);

    // Backpressure: bid2 held 3 cycles, then ask5 last
    set_bid(2, mk(64'h100, 16'd5, 8'd2));
    set_ask(5, mk(64'h200, 16'd7, 8'd3));
    out_ready = 1'b0;
    pulse();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_hold_valid%0d", i), out_valid, 1'b1);
      check($sformatf("t3_hold_data%0d", i), out_data, wd(1'b0, 2, mb[2]));
      check($sformatf("t3_hold_last%0d", i), out_last, 1'b0);
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    exp_q.push_back(wd(1'b1, 5, ma[5]));
    expect_stream("t3");

    // Coalescing: three pulses during a 4-word delta
    set_bid(1, mk(64'h11, 16'd2, 8'd1));
    set_bid(3, mk(64'h33, 16'd4, 8'd2));
    set_ask(0, mk(64'hA0, 16'd6, 8'd3));
    set_ask(9, mk(64'hA9, 16'd8, 8'd4));
    out_ready = 1'b0;
    pulse();
    set_bid(4, mk(64'h44, 16'd9, 8'd5));
    pulse();
    @(negedge clk);
    pulse();
    @(negedge clk);
    pulse();
    check("t4_cnt", coalesce_cnt, 16'd2);
    check("t4_busy", busy, 1'b1);
    check("t4_hold", out_data, wd(1'b0, 1, mb[1]));
    out_ready = 1'b1;
    exp_q.push_back(wd(1'b0, 1, mb[1]));
    exp_q.push_back(wd(1'b0, 3, mb[3]));
    exp_q.push_back(wd(1'b1, 0, ma[0]));
    exp_q.push_back(wd(1'b1, 9, ma[9]));
    expect_stream("t4a");
    check("t4_gap_busy", busy, 1'b0);
    @(negedge clk);
    exp_q.push_back(wd(1'b0, 4, mb[4]));
    expect_stream("t4b");
    check("t4_cnt_after", coalesce_cnt, 16'd2);

    // Reset mid-delta, then full re-emit of nonzero entries
    set_bid(7, mk(64'h77, 16'd3, 8'd7));
    set_ask(3, mk(64'hA3, 16'd5, 8'd9));
    out_ready = 1'b0;
    pulse();
    check("t5_pre_valid", out_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_data", out_data, 128'd0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_last", out_last, 1'b0);
    check("t5_rst_cnt", coalesce_cnt, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    pulse();
    for (int k = 0; k < L; k++) if (mb[k] != '0) exp_q.push_back(wd(1'b0, k, mb[k]));
    for (int k = 0; k < L; k++) if (ma[k] != '0) exp_q.push_back(wd(1'b1, k, ma[k]));
    check("t5_words", exp_q.size(), 10);
    expect_stream("t5");

`ifdef BOOK_DELTA_FULL_REFRESH_EN
    // Latched refresh with unchanged book -> all 20 entries
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    repeat (2) @(negedge clk);
    pulse();
    for (int k = 0; k < L; k++) exp_q.push_back(wd(1'b0, k, mb[k]));
    for (int k = 0; k < L; k++) exp_q.push_back(wd(1'b1, k, ma[k]));
    expect_stream("t6");
`endif

    // Unchanged book after full emission stays silent
    pulse();
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      any = any | out_valid;
      @(negedge clk);
    end
    check("t7_silent", any, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
